// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// bram_stream_reader : streams `count` RAM words from `base_addr` on valid/ready
// Revision 1.0
// ============================================================================
module bram_stream_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [ADDRESS_WIDTH:0]   remaining_issue;
  logic [ADDRESS_WIDTH:0]   remaining_out;
  logic                     inflight;
  logic [DATA_WIDTH-1:0]    buf_mem [2];
  logic [1:0]               buf_count;
  logic                     rd_ptr;
  logic                     wr_ptr;
  logic                     pop;
  logic                     issue;
  logic [2:0]               occupancy;

  assign pop       = out_valid & out_ready;
  // Words that will be held after this edge if nothing new is issued.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && (remaining_issue != '0) && (occupancy < 3'd2);

  assign raddr     = rd_addr;
  assign busy      = (state != IDLE);
  assign out_valid = (buf_count != 2'd0);
  assign out_data  = buf_mem[rd_ptr];
  assign out_last  = out_valid && (remaining_out == CNT_ONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rd_addr         <= '0;
      remaining_issue <= '0;
      remaining_out   <= '0;
      inflight        <= 1'b0;
      buf_mem[0]      <= '0;
      buf_mem[1]      <= '0;
      buf_count       <= 2'd0;
      rd_ptr          <= 1'b0;
      wr_ptr          <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;

      if (inflight) begin
        buf_mem[wr_ptr] <= rdata;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr        <= ~rd_ptr;
        remaining_out <= remaining_out - CNT_ONE;
      end
      buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
      inflight  <= issue;

      if (issue) begin
        rd_addr         <= rd_addr + ADDR_ONE;
        remaining_issue <= remaining_issue - CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              state           <= RUN;
              rd_addr         <= base_addr;
              remaining_issue <= count;
              remaining_out   <= count;
            end
          end
        end
        RUN: begin
          if (issue && (remaining_issue == CNT_ONE)) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// Testbench for bram_stream_reader: table-driven commands against a registered-read RAM model.
module tb_bram_stream_reader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [10:0] base_addr;
  logic [11:0] count;
  logic        busy;
  logic        done;
  logic [10:0] raddr;
  logic [15:0] rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [2048];

  bram_stream_reader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(11)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rdata <= mem[raddr];

  typedef struct {
    int          base;
    int          cnt;
    int          mode;       // 0: ready high, 1: fixed toggle pattern, 2: random
    int          ignore_at;  // cycle at which a stray start is driven, 0 = none
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    logic [5:0] pat;
    pat = 6'b101001;  // bit k gives cycle k of the repeating 1,0,0,1,0,1 sequence
    case (mode)
      0:       return 1'b1;
      1:       return pat[c % 6];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_cmd(input vec_t v);
    int          beats;
    int          c;
    int          budget;
    logic        stall;
    logic [15:0] hold_d;
    logic        hold_l;
    logic [15:0] exp;
    beats  = 0;
    c      = 1;
    stall  = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    budget = v.cnt * 4 + 20;
    @(negedge clock);
    start     = 1'b1;
    base_addr = 11'(v.base);
    count     = 12'(v.cnt);
    out_ready = 1'b1;
    @(negedge clock);
    while (beats < v.cnt && c <= budget) begin
      if (c > 1) @(negedge clock);
      start = (v.ignore_at != 0) && (c == v.ignore_at);
      if (start) begin
        base_addr = 11'd500;
        count     = 12'd5;
      end
      out_ready = ready_for(v.mode, c);
      #1;
      if (c == 1) chk("raddr_after_start", 32'(raddr), 32'(v.base));
      chk("busy_during_run", 32'(busy), 32'd1);
      chk("done_during_run", 32'(done), 32'd0);
      if (stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_d));
        chk("hold_last", 32'(out_last), 32'(hold_l));
      end
      if (out_valid && out_ready) begin
        exp = 16'(((v.base + beats) % 2048) + 'h100);
        chk("beat_data", 32'(out_data), 32'(exp));
        chk("beat_last", 32'(out_last), 32'(beats == v.cnt - 1));
        if (v.mode == 0) chk("beat_cycle", 32'(c), 32'(beats + 3));
        if (beats == 0) chk("first_word", 32'(out_data), 32'(v.exp_first));
        if (beats == v.cnt - 1) chk("last_word", 32'(out_data), 32'(v.exp_last));
        beats++;
      end
      stall  = out_valid && !out_ready;
      hold_d = out_data;
      hold_l = out_last;
      c++;
    end
    start = 1'b0;
    chk("beat_count", 32'(beats), 32'(v.cnt));
    @(negedge clock);
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("valid_after", 32'(out_valid), 32'd0);
    @(negedge clock);
    #1;
    chk("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i + 'h100);

    vecs[0] = '{base: 5,    cnt: 4,    mode: 0, ignore_at: 0, exp_first: 16'h0105, exp_last: 16'h0108};
    vecs[1] = '{base: 2046, cnt: 4,    mode: 0, ignore_at: 0, exp_first: 16'h08FE, exp_last: 16'h0101};
    vecs[2] = '{base: 20,   cnt: 8,    mode: 1, ignore_at: 0, exp_first: 16'h0114, exp_last: 16'h011B};
    vecs[3] = '{base: 100,  cnt: 8,    mode: 2, ignore_at: 0, exp_first: 16'h0164, exp_last: 16'h016B};
    vecs[4] = '{base: 7,    cnt: 3,    mode: 0, ignore_at: 2, exp_first: 16'h0107, exp_last: 16'h0109};
    vecs[5] = '{base: 0,    cnt: 2048, mode: 0, ignore_at: 0, exp_first: 16'h0100, exp_last: 16'h08FF};
    vecs[6] = '{base: 2047, cnt: 1,    mode: 0, ignore_at: 0, exp_first: 16'h08FF, exp_last: 16'h08FF};

    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Zero-length command: immediate done, never busy.
    @(negedge clock);
    start     = 1'b1;
    base_addr = 11'd3;
    count     = 12'd0;
    @(negedge clock);
    start = 1'b0;
    #1;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    #1;
    chk("zero_done_off", 32'(done), 32'd0);
    chk("zero_busy_off", 32'(busy), 32'd0);

    // Stalled command: two words buffered, issue halted, then reset mid-command.
    @(negedge clock);
    start     = 1'b1;
    base_addr = 11'd10;
    count     = 12'd8;
    out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #1;
    chk("stall_raddr", 32'(raddr), 32'd12);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'h10A);
    chk("stall_busy", 32'(busy), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_last", 32'(out_last), 32'd0);
    chk("abort_data", 32'(out_data), 32'd0);
    chk("abort_raddr", 32'(raddr), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    chk("abort_no_done", 32'(done), 32'd0);
    run_cmd('{base: 30, cnt: 2, mode: 0, ignore_at: 0, exp_first: 16'h011E, exp_last: 16'h011F});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
